// File: rtl/btn_mux_pkg.sv
// Shared types and constants for the button-driven mux source stage.
package btn_mux_pkg;

    // Default debounce window: 10 ms at a 100 MHz system clock.
    localparam int unsigned DbCyclesDefault = 1_000_000;

    // Debounce FSM states.
    typedef enum logic [1:0] {
        StIdle  = 2'b00,  // stable low
        StArmHi = 2'b01,  // low-to-high candidate, counting stable high samples
        StHigh  = 2'b10,  // stable high
        StArmLo = 2'b11   // high-to-low candidate, counting stable low samples
    } db_state_e;

endpackage

// File: rtl/btn_mux_src_debounce_pulse.sv
// Synchronizes and debounces one raw push button and emits a single-cycle
// pulse for each accepted press. Releases are debounced but produce no pulse.
module debounce_pulse
    import btn_mux_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DbCyclesDefault
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic press_o
);

    localparam int unsigned CntW = $clog2(DB_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(DB_CYCLES - 1);

    logic [1:0]      sync_q;
    logic            btn_s;
    db_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            press_q, press_d;

    assign btn_s = sync_q[1];

    // Two-flop synchronizer for the asynchronous button input.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], btn_i};
        end
    end

    // State, counter and press-pulse registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    // Next-state logic: a level change is accepted only after DB_CYCLES
    // consecutive agreeing samples in the ARM state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (btn_s) begin
                    state_d = StArmHi;
                    cnt_d   = '0;
                end
            end
            StArmHi: begin
                if (!btn_s) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == CntMax) begin
                    state_d = StHigh;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StHigh: begin
                if (!btn_s) begin
                    state_d = StArmLo;
                    cnt_d   = '0;
                end
            end
            StArmLo: begin
                if (btn_s) begin
                    state_d = StHigh;
                    cnt_d   = '0;
                end else if (cnt_q == CntMax) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    assign press_o = press_q;

endmodule

// File: rtl/btn_mux_src.sv
// Input-capture stage for the lab-board 8-bit 2:1 mux: one debounced button
// toggles the select, the other loads the switches into the selected source.
// Every output is a flop so the mux sees glitch-free operands and select.
module btn_mux_src
    import btn_mux_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DbCyclesDefault
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_sel,
    input  logic       btn_load,
    input  logic [7:0] sw,
    output logic [7:0] i0,
    output logic [7:0] i1,
    output logic       s,
    output logic       load_pulse
);

    logic       sel_press;
    logic       load_press;
    logic       s_q, s_d;
    logic [7:0] i0_q, i0_d;
    logic [7:0] i1_q, i1_d;
    logic       load_pulse_q, load_pulse_d;

    debounce_pulse #(
        .DB_CYCLES(DB_CYCLES)
    ) u_db_sel (
        .clk_i  (clk),
        .rst_i  (rst),
        .btn_i  (btn_sel),
        .press_o(sel_press)
    );

    debounce_pulse #(
        .DB_CYCLES(DB_CYCLES)
    ) u_db_load (
        .clk_i  (clk),
        .rst_i  (rst),
        .btn_i  (btn_load),
        .press_o(load_press)
    );

    // Next values: a load uses the current (pre-toggle) select, so a load and
    // a select press in the same cycle fill the old target while s flips.
    always_comb begin
        s_d          = s_q;
        i0_d         = i0_q;
        i1_d         = i1_q;
        load_pulse_d = load_press;
        if (sel_press) begin
            s_d = ~s_q;
        end
        if (load_press) begin
            if (s_q) begin
                i1_d = sw;
            end else begin
                i0_d = sw;
            end
        end
    end

    // Output registers; sw is quasi-static and captured directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q          <= 1'b0;
            i0_q         <= 8'h00;
            i1_q         <= 8'h00;
            load_pulse_q <= 1'b0;
        end else begin
            s_q          <= s_d;
            i0_q         <= i0_d;
            i1_q         <= i1_d;
            load_pulse_q <= load_pulse_d;
        end
    end

    assign s          = s_q;
    assign i0         = i0_q;
    assign i1         = i1_q;
    assign load_pulse = load_pulse_q;

endmodule

// File: tb/tb_btn_mux_src.sv
// Directed bench for btn_mux_src with DB_CYCLES=4. "Edge 0" is the first
// rising edge after an input change; outputs are sampled 1 ns after an edge.
module tb_btn_mux_src;

    logic       clk;
    logic       rst;
    logic       btn_sel;
    logic       btn_load;
    logic [7:0] sw;
    logic [7:0] i0;
    logic [7:0] i1;
    logic       s;
    logic       load_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    btn_mux_src #(
        .DB_CYCLES(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_sel   (btn_sel),
        .btn_load  (btn_load),
        .sw        (sw),
        .i0        (i0),
        .i1        (i1),
        .s         (s),
        .load_pulse(load_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst      = 1'b1;
        btn_sel  = 1'b0;
        btn_load = 1'b0;
        sw       = 8'h00;

        // Reset held 3 cycles.
        tick(3);
        check("rst_i0", i0, 8'h00);
        check("rst_i1", i1, 8'h00);
        check("rst_s", {7'd0, s}, 8'h00);
        check("rst_lp", {7'd0, load_pulse}, 8'h00);
        rst = 1'b0;
        tick(2);

        // Clean load press with s=0: i0 and load_pulse change at edge 7 only.
        sw       = 8'hA5;
        btn_load = 1'b1;
        for (int e = 0; e < 10; e++) begin
            tick(1);
            check($sformatf("clean_lp_e%0d", e), {7'd0, load_pulse},
                  (e == 7) ? 8'h01 : 8'h00);
            check($sformatf("clean_i0_e%0d", e), i0, (e >= 7) ? 8'hA5 : 8'h00);
        end
        tick(10);
        check("clean_i1", i1, 8'h00);
        check("clean_s", {7'd0, s}, 8'h00);
        btn_load = 1'b0;
        tick(10);
        check("release_no_pulse_i0", i0, 8'hA5);

        // Select press: s rises at edge 7.
        btn_sel = 1'b1;
        for (int e = 0; e < 9; e++) begin
            tick(1);
            check($sformatf("sel_s_e%0d", e), {7'd0, s}, (e >= 7) ? 8'h01 : 8'h00);
        end
        btn_sel = 1'b0;
        tick(10);

        // Load with s=1 targets i1.
        sw       = 8'h3C;
        btn_load = 1'b1;
        tick(8);
        check("ld1_lp", {7'd0, load_pulse}, 8'h01);
        check("ld1_i1", i1, 8'h3C);
        check("ld1_i0", i0, 8'hA5);
        tick(1);
        check("ld1_lp_fall", {7'd0, load_pulse}, 8'h00);
        btn_load = 1'b0;
        tick(10);

        // Bounce: high 3, low 1, high 2, low -> no toggle of s (currently 1).
        btn_sel = 1'b1;
        tick(3);
        btn_sel = 1'b0;
        tick(1);
        btn_sel = 1'b1;
        tick(2);
        btn_sel = 1'b0;
        tick(10);
        check("bounce_s", {7'd0, s}, 8'h01);

        // Stable 10-cycle hold -> exactly one toggle; release adds none.
        btn_sel = 1'b1;
        tick(10);
        check("hold_s", {7'd0, s}, 8'h00);
        btn_sel = 1'b0;
        tick(10);
        check("hold_rel_s", {7'd0, s}, 8'h00);

        // Simultaneous presses with s=0: i0 loads and s toggles on edge 7.
        sw       = 8'hFF;
        btn_sel  = 1'b1;
        btn_load = 1'b1;
        tick(7);
        check("sim_e6_s", {7'd0, s}, 8'h00);
        check("sim_e6_i0", i0, 8'hA5);
        tick(1);
        check("sim_e7_i0", i0, 8'hFF);
        check("sim_e7_s", {7'd0, s}, 8'h01);
        check("sim_e7_i1", i1, 8'h3C);
        btn_sel  = 1'b0;
        btn_load = 1'b0;
        tick(10);

        // Reset mid-count: press, rst on edge 4, debounce restarts afterwards.
        btn_load = 1'b1;
        tick(4);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("mid_rst_i0", i0, 8'h00);
        check("mid_rst_s", {7'd0, s}, 8'h00);
        for (int e = 0; e < 7; e++) begin
            tick(1);
            check($sformatf("mid_nold_e%0d", e), {7'd0, load_pulse}, 8'h00);
        end
        check("mid_i0_pre", i0, 8'h00);
        tick(1);
        check("mid_lp", {7'd0, load_pulse}, 8'h01);
        check("mid_i0", i0, 8'hFF);
        check("mid_i1", i1, 8'h00);
        btn_load = 1'b0;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
